// File: rtl/inst_fetch_queue_pkg.sv
// Shared sizing and queue-operation encoding for the fetch-side instruction queue.
package inst_fetch_queue_pkg;

    localparam int unsigned INST_ADDR_W       = 32;
    localparam int unsigned INST_W            = 32;
    localparam int unsigned FETCH_QUEUE_DEPTH = 4;

    // Pointer/count action applied at the next clock edge
    typedef enum logic [2:0] {
        FQ_OP_NONE  = 3'd0,
        FQ_OP_PUSH  = 3'd1,
        FQ_OP_POP   = 3'd2,
        FQ_OP_BOTH  = 3'd3,
        FQ_OP_FLUSH = 3'd4
    } fq_op_e;

endpackage

// File: rtl/inst_fetch_queue_ram.sv
// DEPTH x WIDTH register array for the fetch queue: one synchronous write port,
// one asynchronous read port.
module fetch_queue_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Payload storage needs no reset; validity is tracked by the controller's count
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch-side instruction queue between PC/ROM and ID: circular FIFO of {pc, inst}.
// Optional same-cycle bypass of an empty queue when FETCH_QUEUE_BYPASS_EN is defined.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = FETCH_QUEUE_DEPTH,
    parameter int unsigned ADDR_W = INST_ADDR_W,
    parameter int unsigned DATA_W = INST_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce_i,
    input  logic [ADDR_W-1:0]        pc_i,
    input  logic [DATA_W-1:0]        inst_i,
    input  logic                     flush_i,
    input  logic                     id_stall_i,
    output logic                     id_valid_o,
    output logic [ADDR_W-1:0]        id_pc_o,
    output logic [DATA_W-1:0]        id_inst_o,
    output logic                     fetch_stall_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               q_empty;
    logic               q_full;
    logic               bypass_c;
    logic               push_c;
    logic               pop_c;
    fq_op_e             op_c;
    logic [ENTRY_W-1:0] head_entry;

    assign q_empty = (count == '0);
    assign q_full  = (count == CNT_W'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue and a ready ID: hand the fetched pair straight through
    assign bypass_c = q_empty && ce_i && !flush_i && !id_stall_i;
`else
    assign bypass_c = 1'b0;
`endif

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early
    assign push_c = ce_i && !q_full && !flush_i && !bypass_c;
    assign pop_c  = !q_empty && !id_stall_i && !flush_i;

    always_comb begin
        op_c = FQ_OP_NONE;
        if (flush_i) begin
            op_c = FQ_OP_FLUSH;
        end else if (push_c && pop_c) begin
            op_c = FQ_OP_BOTH;
        end else if (push_c) begin
            op_c = FQ_OP_PUSH;
        end else if (pop_c) begin
            op_c = FQ_OP_POP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            unique case (op_c)
                FQ_OP_FLUSH: begin
                    rd_ptr <= wr_ptr;
                    count  <= '0;
                end
                FQ_OP_PUSH: begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    count  <= count + CNT_W'(1);
                end
                FQ_OP_POP: begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    count  <= count - CNT_W'(1);
                end
                FQ_OP_BOTH: begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    fetch_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push_c),
        .waddr (wr_ptr),
        .wdata ({pc_i, inst_i}),
        .raddr (rd_ptr),
        .rdata (head_entry)
    );

    // Head view: stored entry, else bypassed fetch, else zeros (NOP)
    always_comb begin
        id_valid_o = 1'b0;
        id_pc_o    = '0;
        id_inst_o  = '0;
        if (!q_empty) begin
            id_valid_o = 1'b1;
            id_pc_o    = head_entry[ENTRY_W-1:DATA_W];
            id_inst_o  = head_entry[DATA_W-1:0];
        end else if (bypass_c) begin
            id_valid_o = 1'b1;
            id_pc_o    = pc_i;
            id_inst_o  = inst_i;
        end
    end

    assign fetch_stall_o = q_full;
    assign count_o       = count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized and directed bench for inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic        flush_i;
    logic        id_stall_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        fetch_stall_o;
    logic [2:0]  count_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] model[$];

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .ce_i          (ce_i),
        .pc_i          (pc_i),
        .inst_i        (inst_i),
        .flush_i       (flush_i),
        .id_stall_i    (id_stall_i),
        .id_valid_o    (id_valid_o),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o),
        .fetch_stall_o (fetch_stall_o),
        .count_o       (count_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs, compare outputs against the model, clock, advance the model
    task automatic step(input bit r, input bit ce, input logic [31:0] pc, input logic [31:0] inst,
                        input bit fl, input bit st);
        bit          byp;
        bit          do_pop;
        bit          do_push;
        logic [63:0] head;
        rst = r; ce_i = ce; pc_i = pc; inst_i = inst; flush_i = fl; id_stall_i = st;
        #1;
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (model.size() == 0) && ce && !fl && !st;
`endif
        if (model.size() != 0) head = model[0];
        else if (byp)          head = {pc, inst};
        else                   head = 64'h0;
        check_eq("id_valid", 64'(id_valid_o), 64'(model.size() != 0 || byp));
        check_eq("id_pc", 64'(id_pc_o), 64'(head[63:32]));
        check_eq("id_inst", 64'(id_inst_o), 64'(head[31:0]));
        check_eq("fetch_stall", 64'(fetch_stall_o), 64'(model.size() == DEPTH));
        check_eq("count", 64'(count_o), 64'(model.size()));
        @(posedge clk);
        if (r || fl) begin
            model.delete();
        end else begin
            do_pop  = (model.size() != 0) && !st;
            do_push = ce && (model.size() < DEPTH) && !byp;
            if (do_pop)  void'(model.pop_front());
            if (do_push) model.push_back({pc, inst});
        end
        @(negedge clk);
    endtask

    // Quiet inputs so explicit checks see registered state only
    task automatic hold_inputs();
        rst = 1'b0; ce_i = 1'b0; flush_i = 1'b0; id_stall_i = 1'b1;
        #1;
    endtask

    initial begin
        rst = 1'b1; ce_i = 1'b0; pc_i = '0; inst_i = '0; flush_i = 1'b0; id_stall_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model.delete();

        // Reset state
        hold_inputs();
        check_eq("reset_count", 64'(count_o), 64'd0);
        check_eq("reset_valid", 64'(id_valid_o), 64'd0);
        check_eq("reset_pc", 64'(id_pc_o), 64'd0);

        // Streaming with ID always ready
        step(0, 1, 32'h00, 32'h11, 0, 0);
        step(0, 1, 32'h04, 32'h22, 0, 0);
        step(0, 1, 32'h08, 32'h33, 0, 0);
        step(0, 0, 32'h0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 32'h0, 0, 0);

        // Fill under stall, 5th refused, then drain in order
        for (int i = 0; i < 5; i++) step(0, 1, 32'(i * 4), 32'hA0 + 32'(i), 0, 1);
        hold_inputs();
        check_eq("full_count", 64'(count_o), 64'd4);
        check_eq("full_stall", 64'(fetch_stall_o), 64'd1);
        check_eq("full_head", 64'(id_pc_o), 64'h0);
        for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 32'h0, 0, 0);

        // Flush with three queued and a same-cycle fetch
        for (int i = 0; i < 3; i++) step(0, 1, 32'h30 + 32'(i * 4), 32'hB0, 0, 1);
        step(0, 1, 32'h40, 32'hBB, 1, 1);
        hold_inputs();
        check_eq("flush_count", 64'(count_o), 64'd0);
        check_eq("flush_valid", 64'(id_valid_o), 64'd0);
        step(0, 1, 32'h100, 32'hCC, 0, 1);
        step(0, 0, 32'h0, 32'h0, 0, 0);

        // Full queue with same-cycle dequeue and fetch
        for (int i = 0; i < 4; i++) step(0, 1, 32'h200 + 32'(i * 4), 32'hD0, 0, 1);
        step(0, 1, 32'h210, 32'hD4, 0, 0);
        hold_inputs();
        check_eq("full_pop_count", 64'(count_o), 64'd3);
        step(0, 1, 32'h210, 32'hD4, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 32'h0, 0, 0);

        // Continuous push/pop to wrap the pointers
        for (int i = 0; i < 10; i++) step(0, 1, 32'h300 + 32'(i * 4), 32'(i), 0, (i % 3) == 0);
        for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 32'h0, 0, 0);

        // Reset beats flush with entries queued
        step(0, 1, 32'h400, 32'hE0, 0, 1);
        step(0, 1, 32'h404, 32'hE1, 0, 1);
        step(1, 1, 32'h408, 32'hE2, 1, 0);
        hold_inputs();
        check_eq("rst_count", 64'(count_o), 64'd0);
        check_eq("rst_valid", 64'(id_valid_o), 64'd0);
        check_eq("rst_inst", 64'(id_inst_o), 64'd0);
        check_eq("rst_stall", 64'(fetch_stall_o), 64'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
        rst = 1'b0; ce_i = 1'b1; pc_i = 32'h20; inst_i = 32'h55; flush_i = 1'b0; id_stall_i = 1'b0;
        #1;
        check_eq("bypass_pc", 64'(id_pc_o), 64'h20);
        check_eq("bypass_valid", 64'(id_valid_o), 64'd1);
`endif
        step(0, 1, 32'h20, 32'h55, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 7,
                 32'($urandom) & 32'hFFFF_FFFC, 32'($urandom),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
